// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//
// Shared definitions for the router output-port drain engine.
//
// Contents:
//   state_e                 - drain FSM states (IDLE, WAIT, PRESENT, STALL)
//   LEN_MSB / LEN_LSB       - header field holding the payload length
//   ADDR_MSB / ADDR_LSB     - header field holding the destination address
//   DEFAULT_TIMEOUT_CYCLES  - un-read cycles tolerated before a FIFO flush
//   DEFAULT_TMR_W           - timer width that can hold DEFAULT_TIMEOUT_CYCLES
//   hdr_len() / hdr_addr()  - header field extractors
// -----------------------------------------------------------------------------
package router_pkg;

    // Drain FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no packet in flight, waiting for FIFO data
        ST_WAIT    = 2'd1,  // FIFO read issued, data arrives this cycle
        ST_PRESENT = 2'd2,  // byte offered to the destination
        ST_STALL   = 2'd3   // mid-packet, FIFO ran dry
    } state_e;

    // Header layout: [7:2] payload length, [1:0] address.
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_W = ADDR_MSB - ADDR_LSB + 1;

    // Default flush timeout and a timer width that can count up to it.
    localparam int DEFAULT_TIMEOUT_CYCLES = 30;
    localparam int DEFAULT_TMR_W          = 5;

    // Payload length carried in a header byte.
    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    // Destination address carried in a header byte.
    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage : router_pkg

// File: rtl/router_timeout_ctr.sv
// -----------------------------------------------------------------------------
// router_timeout_ctr
//
// Clear/enable up-counter with a terminal-count flag. Used by the output port
// to measure how long a byte has been offered without being read.
//
// Parameters:
//   TIMEOUT_CYCLES - terminal count is flagged when the count equals
//                    TIMEOUT_CYCLES-1 (the last tolerated un-read cycle)
//   TMR_W          - counter width; 2**TMR_W must exceed TIMEOUT_CYCLES
//
// Ports:
//   clock   in  system clock, rising edge
//   resetn  in  synchronous active-low reset
//   clr_i   in  force the count to zero next cycle (wins over en_i)
//   en_i    in  increment the count next cycle
//   tc_o    out count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module router_timeout_ctr
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMR_W          = DEFAULT_TMR_W
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // NOTE: every combinational output gets a default assignment first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule : router_timeout_ctr

// File: rtl/router_out_port.sv
// -----------------------------------------------------------------------------
// router_out_port
//
// Read-side drain engine for one router output channel. Pulls one packet at a
// time from a registered-read FIFO (one-cycle read latency), offers each byte
// to the destination with a vld_out/dst_read handshake, checks the trailing
// parity byte, and flushes the FIFO if the destination stops reading.
//
// Packet: header {len[5:0], addr[1:0]}, len payload bytes, parity byte equal
// to the XOR of header and payload.
//
// Parameters:
//   TIMEOUT_CYCLES - consecutive un-read vld_out cycles before a flush
//   TMR_W          - timeout timer width, 2**TMR_W > TIMEOUT_CYCLES
//
// Ports:
//   clock            in   system clock, rising edge
//   resetn           in   synchronous active-low reset
//   fifo_empty       in   FIFO empty flag
//   fifo_data[7:0]   in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd          out  FIFO read enable (combinational)
//   fifo_soft_reset  out  one-cycle FIFO flush on timeout (combinational)
//   dst_read         in   destination takes data_out this cycle
//   vld_out          out  data_out holds a byte for the destination
//   data_out[7:0]    out  byte offered to the destination
//   pkt_done         out  registered pulse after the parity byte is taken
//   parity_err       out  with pkt_done when the parity byte mismatched
//   timeout          out  registered pulse the cycle after fifo_soft_reset
// -----------------------------------------------------------------------------
module router_out_port
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMR_W          = DEFAULT_TMR_W
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       fifo_soft_reset,
    input  logic       dst_read,
    output logic       vld_out,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       timeout
);

    state_e           state_q;
    logic [7:0]       data_q;        // byte on data_out, held while not valid
    logic             hdr_q;         // the byte in flight is the header
    logic [LEN_W-1:0] remaining_q;   // bytes still to come after the current one
    logic [7:0]       par_acc_q;     // running XOR of header and payload
    logic             pkt_done_q;
    logic             parity_err_q;
    logic             timeout_q;

    logic             last_byte;     // current byte is the parity byte
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_tc;

    assign vld_out   = (state_q == ST_PRESENT);
    assign last_byte = (remaining_q == '0);

    // The timer only runs while a byte is offered and not taken; any accept or
    // any other state restarts it so each byte gets a full timeout window.
    assign tmr_clr = !vld_out || dst_read;
    assign tmr_en  = vld_out && !dst_read;

    router_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timeout_ctr (
        .clock  (clock),
        .resetn (resetn),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    // FIFO strobes are decoded from the current state so the read lands in the
    // same cycle the decision is made. Reset masks them because IDLE alone
    // would otherwise read a non-empty FIFO while reset is held.
    always_comb begin
        fifo_rd         = 1'b0;
        fifo_soft_reset = 1'b0;
        if (resetn) begin
            unique case (state_q)
                ST_IDLE, ST_STALL: begin
                    fifo_rd = !fifo_empty;
                end
                ST_PRESENT: begin
                    if (dst_read) begin
                        fifo_rd = !last_byte && !fifo_empty;
                    end else begin
                        fifo_soft_reset = tmr_tc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            data_q       <= 8'h00;
            hdr_q        <= 1'b0;
            remaining_q  <= '0;
            par_acc_q    <= 8'h00;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            timeout_q    <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        hdr_q   <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    data_q <= fifo_data;
                    if (hdr_q) begin
                        // Payload plus the parity byte. A length of 63 wraps
                        // to 0 in the 6-bit counter.
                        remaining_q <= hdr_len(fifo_data) + LEN_W'(1);
                        par_acc_q   <= fifo_data;
                    end
                    state_q <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (dst_read) begin
                        if (last_byte) begin
                            pkt_done_q   <= 1'b1;
                            parity_err_q <= (par_acc_q != data_q);
                            state_q      <= ST_IDLE;
                        end else begin
                            remaining_q <= remaining_q - LEN_W'(1);
                            // The header already seeded the accumulator.
                            if (!hdr_q) begin
                                par_acc_q <= par_acc_q ^ data_q;
                            end
                            hdr_q   <= 1'b0;
                            state_q <= fifo_empty ? ST_STALL : ST_WAIT;
                        end
                    end else if (tmr_tc) begin
                        // Flush: the FIFO is cleared by fifo_soft_reset this
                        // cycle, so whatever is left of the packet is dropped.
                        hdr_q       <= 1'b0;
                        remaining_q <= '0;
                        par_acc_q   <= 8'h00;
                        timeout_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_STALL: begin
                    if (!fifo_empty) begin
                        state_q <= ST_WAIT;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign timeout    = timeout_q;

endmodule : router_out_port

// File: tb/tb_router_out_port.sv
// -----------------------------------------------------------------------------
// tb_router_out_port
//
// Directed bench for router_out_port. A behavioural registered-read FIFO
// feeds the DUT; each scenario task drives the destination handshake and
// compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_router_out_port;

    logic       clock;
    logic       resetn;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       fifo_soft_reset;
    logic       dst_read;
    logic       vld_out;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       parity_err;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Behavioural FIFO contents and per-drain observations.
    logic [7:0] fifo_q [$];
    logic [7:0] got    [$];
    int         first_vld_i;
    int         last_acc_i;
    int         done_i;

    router_out_port dut (
        .clock           (clock),
        .resetn          (resetn),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .fifo_rd         (fifo_rd),
        .fifo_soft_reset (fifo_soft_reset),
        .dst_read        (dst_read),
        .vld_out         (vld_out),
        .data_out        (data_out),
        .pkt_done        (pkt_done),
        .parity_err      (parity_err),
        .timeout         (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign fifo_empty = (fifo_q.size() == 0);

    // Registered-read FIFO: a read sampled in cycle N presents data in N+1;
    // a soft reset empties it at the same edge.
    logic mdl_rd;
    logic mdl_sr;
    always begin
        @(negedge clock);
        #2;
        mdl_rd = fifo_rd;
        mdl_sr = fifo_soft_reset;
        @(posedge clock);
        #1;
        if (mdl_sr) begin
            fifo_q.delete();
        end else if (mdl_rd && fifo_q.size() > 0) begin
            fifo_data = fifo_q.pop_front();
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    // Runs with a fixed dst_read until pkt_done or the cycle budget. Must be
    // called at a falling edge. Records accepted bytes and event cycles.
    task automatic drain(input bit rd, input int budget,
                         output int nrd, output bit done, output bit perr);
        nrd         = 0;
        done        = 1'b0;
        perr        = 1'b0;
        first_vld_i = -1;
        last_acc_i  = -1;
        done_i      = -1;
        got.delete();
        dst_read = rd;
        for (int i = 0; i < budget && !done; i++) begin
            #1;
            if (fifo_rd) nrd++;
            if (vld_out && first_vld_i < 0) first_vld_i = i;
            if (vld_out && dst_read) begin
                got.push_back(data_out);
                last_acc_i = i;
            end
            if (pkt_done) begin
                done   = 1'b1;
                perr   = parity_err;
                done_i = i;
            end
            @(negedge clock);
            dst_read = rd;
        end
    endtask

    // Counts vld_out cycles up to n; dst_read rises only on the n-th one when
    // rd_last is set. Reports where fifo_soft_reset fired (vld cycle index).
    task automatic hold_vld(input int n, input bit rd_last, output int vc,
                            output int sr_at, output bit clash,
                            output bit unstable, output logic [7:0] seen);
        vc       = 0;
        sr_at    = 0;
        clash    = 1'b0;
        unstable = 1'b0;
        seen     = 8'h00;
        for (int i = 0; i < n + 10 && vc < n; i++) begin
            @(negedge clock);
            dst_read = rd_last && (vc == n - 1);
            #1;
            if (fifo_rd && fifo_soft_reset) clash = 1'b1;
            if (vld_out) begin
                if (vc == 0) seen = data_out;
                else if (data_out !== seen) unstable = 1'b1;
                vc++;
                if (fifo_soft_reset && sr_at == 0) sr_at = vc;
            end
        end
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        dst_read = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({vld_out, fifo_rd, fifo_soft_reset, pkt_done, parity_err, timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {vld_out, fifo_rd, fifo_soft_reset, pkt_done, parity_err, timeout});
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", data_out);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_basic_packet();
        logic [7:0] exp_b [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        int nrd;
        bit done, perr;
        @(negedge clock);
        foreach (exp_b[k]) push_byte(exp_b[k]);
        drain(1'b1, 20, nrd, done, perr);
        checks++;
        if (got.size() != 5) begin
            failures++;
            $display("FAIL basic_nbytes got=%0d exp=5", got.size());
        end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_b[k]) begin
                failures++;
                $display("FAIL basic_byte%0d got=%h exp=%h", k, got[k], exp_b[k]);
            end
        end
        checks++;
        if (nrd != 5) begin
            failures++;
            $display("FAIL basic_fifo_rd_count got=%0d exp=5", nrd);
        end
        checks++;
        if (first_vld_i != 2) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=2", first_vld_i);
        end
        checks++;
        if (last_acc_i != 10) begin
            failures++;
            $display("FAIL basic_throughput last_accept got=%0d exp=10", last_acc_i);
        end
        checks++;
        if (!done || done_i != last_acc_i + 1) begin
            failures++;
            $display("FAIL basic_pkt_done done=%0d at=%0d exp_at=%0d", done, done_i, last_acc_i + 1);
        end
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL basic_parity_err got=%b exp=0", perr);
        end
        #1;
        checks++;
        if (vld_out !== 1'b0 || data_out !== 8'h0C) begin
            failures++;
            $display("FAIL basic_idle_hold vld=%b data=%h exp vld=0 data=0c", vld_out, data_out);
        end
    endtask

    task automatic test_parity_error();
        int nrd;
        bit done, perr;
        @(negedge clock);
        push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22);
        push_byte(8'h33); push_byte(8'h0D);
        drain(1'b1, 20, nrd, done, perr);
        checks++;
        if (got.size() != 5) begin
            failures++;
            $display("FAIL perr_nbytes got=%0d exp=5", got.size());
        end
        checks++;
        if (!done || perr !== 1'b1) begin
            failures++;
            $display("FAIL perr_flag done=%0d parity_err=%b exp done=1 parity_err=1", done, perr);
        end
    endtask

    task automatic test_timeout();
        int vc, sr_at, nrd;
        bit clash, unstable, done, perr;
        logic [7:0] seen;
        @(negedge clock);
        push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22);
        push_byte(8'h33); push_byte(8'h0C);
        hold_vld(30, 1'b0, vc, sr_at, clash, unstable, seen);
        checks++;
        if (sr_at != 30) begin
            failures++;
            $display("FAIL timeout_sr_cycle got=%0d exp=30 (vld cycles seen %0d)", sr_at, vc);
        end
        checks++;
        if (seen !== 8'h0C || unstable) begin
            failures++;
            $display("FAIL timeout_hold_data got=%h unstable=%0d exp=0c", seen, unstable);
        end
        checks++;
        if (clash) begin
            failures++;
            $display("FAIL timeout_rd_sr_overlap got=1 exp=0");
        end
        @(negedge clock);
        dst_read = 1'b0;
        #1;
        checks++;
        if (vld_out !== 1'b0 || timeout !== 1'b1 || fifo_soft_reset !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse vld=%b timeout=%b sr=%b exp 0 1 0",
                     vld_out, timeout, fifo_soft_reset);
        end
        @(negedge clock);
        #1;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_one_cycle got=%b exp=0", timeout);
        end
        // Minimal L=0 packet from a fresh IDLE after the flush.
        @(negedge clock);
        push_byte(8'h01); push_byte(8'h01);
        drain(1'b1, 12, nrd, done, perr);
        checks++;
        if (got.size() != 2 || got[0] !== 8'h01 || got[1] !== 8'h01) begin
            failures++;
            $display("FAIL zero_len_bytes size=%0d exp 2 bytes of 01", got.size());
        end
        checks++;
        if (!done || perr !== 1'b0 || first_vld_i != 2) begin
            failures++;
            $display("FAIL zero_len_done done=%0d perr=%b first_vld=%0d exp 1 0 2",
                     done, perr, first_vld_i);
        end
    endtask

    task automatic test_last_cycle_read();
        int vc, sr_at, nrd;
        bit clash, unstable, done, perr;
        logic [7:0] seen;
        @(negedge clock);
        push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22);
        push_byte(8'h33); push_byte(8'h0C);
        hold_vld(30, 1'b1, vc, sr_at, clash, unstable, seen);
        checks++;
        if (vc != 30 || sr_at != 0 || seen !== 8'h0C) begin
            failures++;
            $display("FAIL race_header vc=%0d sr_at=%0d data=%h exp 30 0 0c", vc, sr_at, seen);
        end
        // Second full window for the next byte proves the timer restarted.
        hold_vld(30, 1'b1, vc, sr_at, clash, unstable, seen);
        checks++;
        if (vc != 30 || sr_at != 0 || seen !== 8'h11) begin
            failures++;
            $display("FAIL race_payload vc=%0d sr_at=%0d data=%h exp 30 0 11", vc, sr_at, seen);
        end
        @(negedge clock);
        drain(1'b1, 20, nrd, done, perr);
        checks++;
        if (got.size() != 3 || !done || perr !== 1'b0) begin
            failures++;
            $display("FAIL race_tail nbytes=%0d done=%0d perr=%b exp 3 1 0", got.size(), done, perr);
        end
    endtask

    task automatic test_stall();
        int nrd;
        bit done, perr, bad_vld, bad_data;
        @(negedge clock);
        push_byte(8'h0C); push_byte(8'h11);
        drain(1'b1, 8, nrd, done, perr);
        checks++;
        if (got.size() != 2 || done) begin
            failures++;
            $display("FAIL stall_prefix nbytes=%0d done=%0d exp 2 0", got.size(), done);
        end
        bad_vld  = 1'b0;
        bad_data = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #1;
            if (vld_out !== 1'b0) bad_vld = 1'b1;
            if (data_out !== 8'h11) bad_data = 1'b1;
        end
        checks++;
        if (bad_vld) begin
            failures++;
            $display("FAIL stall_vld got=1 exp=0");
        end
        checks++;
        if (bad_data) begin
            failures++;
            $display("FAIL stall_data_hold got=%h exp=11", data_out);
        end
        @(negedge clock);
        push_byte(8'h22); push_byte(8'h33); push_byte(8'h0C);
        drain(1'b1, 20, nrd, done, perr);
        checks++;
        if (got.size() != 3 || got[0] !== 8'h22) begin
            failures++;
            $display("FAIL stall_resume nbytes=%0d first=%h exp 3 22",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if (!done || perr !== 1'b0 || first_vld_i != 2) begin
            failures++;
            $display("FAIL stall_done done=%0d perr=%b first_vld=%0d exp 1 0 2",
                     done, perr, first_vld_i);
        end
    endtask

    task automatic test_reset_mid_packet();
        int nrd;
        bit done, perr;
        @(negedge clock);
        push_byte(8'h0C); push_byte(8'h11); push_byte(8'h22);
        push_byte(8'h33); push_byte(8'h0C);
        drain(1'b1, 4, nrd, done, perr);
        dst_read = 1'b0;
        #1;
        checks++;
        if (vld_out !== 1'b1 || data_out !== 8'h11) begin
            failures++;
            $display("FAIL midrst_pre vld=%b data=%h exp 1 11", vld_out, data_out);
        end
        resetn = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (vld_out !== 1'b0 || data_out !== 8'h00 || fifo_rd !== 1'b0 || pkt_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state vld=%b data=%h rd=%b done=%b exp 0 00 0 0",
                     vld_out, data_out, fifo_rd, pkt_done);
        end
        fifo_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (vld_out !== 1'b0 || fifo_rd !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle vld=%b rd=%b exp 0 0", vld_out, fifo_rd);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        dst_read  = 1'b0;
        fifo_data = 8'h00;
        test_reset();
        test_basic_packet();
        test_parity_error();
        test_timeout();
        test_last_cycle_read();
        test_stall();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule : tb_router_out_port
